// File: rtl/apogeo_pkg.sv
// Shared commit-stage types, default sizing and the round-robin wrap helper.
package apogeo_pkg;

    localparam int unsigned COMMIT_CHANNELS = 3;
    localparam int unsigned COMMIT_DEPTH    = 8;
    localparam int unsigned COMMIT_DATA_W   = 32;
    localparam int unsigned COMMIT_TAG_W    = 6;
    localparam int unsigned COMMIT_META_W   = 16;

    typedef struct packed {
        logic [COMMIT_DATA_W-1:0] data;
        logic [COMMIT_TAG_W-1:0]  tag;
        logic [COMMIT_META_W-1:0] meta;
    } commit_entry_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous show-ahead FIFO with async reset and synchronous flush.
module commit_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (do_push & ~do_pop)
            cnt_d = cnt_q + 1'b1;
        else if (do_pop & ~do_push)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // Storage is not reset: the head is only observed while the FIFO is non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push & ~flush_i)
            mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/commit_arbiter.sv
// Commit stage: per-channel FIFOs with empty-FIFO bypass, drained round-robin into the ROB.
module commit_arbiter
    import apogeo_pkg::*;
#(
    parameter int unsigned NUM_CH = COMMIT_CHANNELS,
    parameter int unsigned DEPTH  = COMMIT_DEPTH,
    parameter int unsigned DATA_W = COMMIT_DATA_W,
    parameter int unsigned TAG_W  = COMMIT_TAG_W,
    parameter int unsigned META_W = COMMIT_META_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic [NUM_CH-1:0]        valid_i,
    output logic [NUM_CH-1:0]        ready_o,
    input  logic [NUM_CH*DATA_W-1:0] result_i,
    input  logic [NUM_CH*TAG_W-1:0]  tag_i,
    input  logic [NUM_CH*META_W-1:0] meta_i,
    input  logic                     rob_ready_i,
    output logic                     rob_write_o,
    output logic [TAG_W-1:0]         rob_tag_o,
    output logic [DATA_W-1:0]        rob_data_o,
    output logic [META_W-1:0]        rob_meta_o,
    output logic [NUM_CH-1:0]        fwd_valid_o,
    output logic [NUM_CH*DATA_W-1:0] fwd_data_o
);
    localparam int unsigned CH_W = $clog2(NUM_CH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
        logic [META_W-1:0] meta;
    } entry_t;

    entry_t            in_ent [NUM_CH];
    entry_t            head   [NUM_CH];
    entry_t            sel;
    logic [NUM_CH-1:0] full, empty, req, push, pop;
    logic [CH_W-1:0]   rr_q, rr_d, gnt;
    logic              any_req, wr_en, granted;
    int unsigned       idx;

    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            in_ent[c].data = result_i[c*DATA_W +: DATA_W];
            in_ent[c].tag  = tag_i[c*TAG_W +: TAG_W];
            in_ent[c].meta = meta_i[c*META_W +: META_W];
            fwd_data_o[c*DATA_W +: DATA_W] =
                (valid_i[c] & rst_n_i) ? result_i[c*DATA_W +: DATA_W] : '0;
        end
    end

    assign req         = ~empty | valid_i;
    assign ready_o     = ~full;
    assign fwd_valid_o = valid_i & {NUM_CH{rst_n_i}};

    // Walking from the RR pointer is the rotate / priority-encode / rotate-back in one loop.
    always_comb begin
        gnt     = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_q) + i) % NUM_CH;
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                gnt     = CH_W'(idx);
            end
        end
    end

    assign wr_en       = any_req & ~flush_i & rst_n_i;
    assign sel         = empty[gnt] ? in_ent[gnt] : head[gnt];
    assign rob_write_o = wr_en;
    assign rob_tag_o   = wr_en ? sel.tag  : '0;
    assign rob_data_o  = wr_en ? sel.data : '0;
    assign rob_meta_o  = wr_en ? sel.meta : '0;

    // A bypassed input only lands in its FIFO when the ROB refuses it.
    always_comb begin
        push    = '0;
        pop     = '0;
        granted = 1'b0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            granted = wr_en && (int'(gnt) == c);
            pop[c]  = granted & ~empty[c] & rob_ready_i;
            push[c] = valid_i[c] & ~full[c] & ~flush_i &
                      ~(granted & empty[c] & rob_ready_i);
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (flush_i)
            rr_d = '0;
        else if (wr_en & rob_ready_i)
            rr_d = CH_W'(rr_next(int'(gnt), NUM_CH));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rr_q <= '0;
        else          rr_q <= rr_d;
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        commit_fifo #(
            .DEPTH(DEPTH),
            .WIDTH($bits(entry_t))
        ) u_fifo (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .flush_i(flush_i),
            .push_i (push[g]),
            .pop_i  (pop[g]),
            .data_i (in_ent[g]),
            .data_o (head[g]),
            .full_o (full[g]),
            .empty_o(empty[g])
        );
    end

endmodule
